// File: rtl/water_scanner.sv
// Water bitmap ROM scanner: fetches NUM_CHUNKS chunk words for one animation
// phase and serialises each MSB-first onto a valid/ready pixel stream.
module water_scanner #(
   parameter int WIDTH      = 590,
   parameter int NUM_CHUNKS = 5,
   parameter int PHASE_W    = 3,
   parameter int CHUNK_W    = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       abort,
   input  logic [PHASE_W-1:0]         phase,
   output logic                       rom_en,
   output logic [PHASE_W+CHUNK_W-1:0] rom_addr,
   input  logic [WIDTH-1:0]           rom_bitmap,
   output logic                       pix_valid,
   input  logic                       pix_ready,
   output logic                       pix_data,
   output logic                       pix_sol,
   output logic                       pix_last,
   output logic                       busy,
   output logic                       done
);

   localparam int BC_W = $clog2(WIDTH);
   localparam logic [BC_W-1:0]    BIT_TOP   = BC_W'(WIDTH - 1);
   localparam logic [CHUNK_W-1:0] CHUNK_TOP = CHUNK_W'(NUM_CHUNKS - 1);

   typedef enum logic [2:0] {IDLE, ADDR, LOAD, SHIFT, DONE} state_t;

   state_t              state, state_nx;
   logic [PHASE_W-1:0]  phase_q;
   logic [CHUNK_W-1:0]  chunk;
   logic [BC_W-1:0]     bitcnt;
   logic [WIDTH-1:0]    shreg;

   logic take_start, do_load, accept, next_chunk;
   logic last_bit, last_chunk;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      rom_en     = 1'b0;
      pix_valid  = 1'b0;
      done       = 1'b0;
      take_start = 1'b0;
      do_load    = 1'b0;
      accept     = 1'b0;
      next_chunk = 1'b0;
      last_bit   = (bitcnt == '0);
      last_chunk = (chunk == CHUNK_TOP);

      case (state)
         IDLE: begin
            if (start) begin
               take_start = 1'b1;
               state_nx   = ADDR;
            end
         end
         // ROM output is only valid while rom_en stays high, so both the
         // address cycle and the capture cycle keep it asserted.
         ADDR: begin
            rom_en   = 1'b1;
            state_nx = LOAD;
         end
         LOAD: begin
            rom_en   = 1'b1;
            do_load  = 1'b1;
            state_nx = SHIFT;
         end
         SHIFT: begin
            pix_valid = 1'b1;
            accept    = pix_ready;
            if (pix_ready && last_bit) begin
               if (last_chunk) begin
                  state_nx = DONE;
               end else begin
                  next_chunk = 1'b1;
                  state_nx   = ADDR;
               end
            end
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase

      // Cancel overrides everything, including a simultaneous start in IDLE.
      if (abort) begin
         state_nx   = IDLE;
         take_start = 1'b0;
         do_load    = 1'b0;
         accept     = 1'b0;
         next_chunk = 1'b0;
      end

      rom_addr = {phase_q, chunk};
      pix_data = pix_valid & shreg[WIDTH-1];
      pix_sol  = pix_valid & (bitcnt == BIT_TOP);
      pix_last = pix_valid & last_bit & last_chunk;
      busy     = (state != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q <= '0;
         chunk   <= '0;
         bitcnt  <= '0;
         shreg   <= '0;
      end else begin
         if (take_start) begin
            phase_q <= phase;
            chunk   <= '0;
         end
         if (next_chunk) chunk <= chunk + CHUNK_W'(1);
         if (do_load) begin
            shreg  <= rom_bitmap;
            bitcnt <= BIT_TOP;
         end else if (accept) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
            if (!last_bit) bitcnt <= bitcnt - BC_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_water_scanner.sv
// Directed/randomised bench for water_scanner with a behavioural ROM and a
// beat-index reference model of the expected pixel stream.
module tb_water_scanner;
   localparam int W     = 590;
   localparam int NC    = 5;
   localparam int BEATS = W * NC;

   logic         clk = 1'b0;
   logic         rst, start, abort, pix_ready;
   logic [2:0]   phase;
   logic         rom_en;
   logic [5:0]   rom_addr;
   logic [W-1:0] rom_bitmap;
   logic         pix_valid, pix_data, pix_sol, pix_last, busy, done;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] mem [64];
   logic [W-1:0] garbage;
   logic [5:0]   addr_q;
   logic         rom_vld = 1'b0;

   always #5 clk = ~clk;

   water_scanner #(.WIDTH(W), .NUM_CHUNKS(NC), .PHASE_W(3), .CHUNK_W(3)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .phase(phase),
      .rom_en(rom_en), .rom_addr(rom_addr), .rom_bitmap(rom_bitmap),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
      .pix_sol(pix_sol), .pix_last(pix_last), .busy(busy), .done(done)
   );

   // Registered-address ROM; data is junk unless rom_en was high last edge and still is.
   always @(posedge clk) begin
      rom_vld <= rom_en;
      if (rom_en) addr_q <= rom_addr;
   end
   assign rom_bitmap = (rom_vld && rom_en) ? mem[addr_q] : garbage;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_bit(input int p, input int n);
      logic [W-1:0] w;
      w = mem[p * 8 + n / W];
      return w[W - 1 - (n % W)];
   endfunction

   task automatic watch_no_done(input int ncyc);
      int extra;
      extra = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         if (done) extra++;
      end
      chk("no_spurious_done", 32'(extra), 32'd0);
   endtask

   // One scan: cut_beat >= 0 interrupts the scan (abort, or rst if cut_rst) at that beat.
   task automatic scan(input int p, input bit rnd, input bit hold, input int cut_beat, input bit cut_rst);
      int n, cyc, dones;
      bit pv, pr, seen, fin, cut;
      logic pd, ps, pl;
      n = 0; cyc = 0; dones = 0;
      pv = 0; pr = 0; seen = 0; fin = 0;
      pd = 0; ps = 0; pl = 0;
      cut = (cut_beat >= 0);
      @(posedge clk); #1;
      phase = 3'(p); start = 1'b1; pix_ready = 1'b1;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      phase = 3'($urandom);
      pix_ready = rnd ? 1'($urandom) : 1'b1;
      while (!fin && cyc < 20000) begin
         @(negedge clk);
         if (rom_en && n < BEATS) chk("rom_addr", 32'(rom_addr), 32'({3'(p), 3'(n / W)}));
         if (pix_valid) begin
            if (!seen) begin
               seen = 1;
               chk("first_valid_cycle", 32'(cyc), 32'd2);
            end
            if (n >= BEATS) chk("beat_overrun", 32'(n), 32'(BEATS - 1));
            else begin
               chk("pix_data", 32'(pix_data), 32'(exp_bit(p, n)));
               chk("pix_sol", 32'(pix_sol), 32'(n % W == 0));
               chk("pix_last", 32'(pix_last), 32'(n == BEATS - 1));
            end
            if (pv && !pr) begin
               chk("stall_data", 32'(pix_data), 32'(pd));
               chk("stall_sol", 32'(pix_sol), 32'(ps));
               chk("stall_last", 32'(pix_last), 32'(pl));
            end
         end else if (pv && !pr) begin
            chk("valid_drop", 32'(pix_valid), 32'd1);
         end
         if (done) begin
            dones++;
            if (!rnd) chk("done_cycle", 32'(cyc), 32'd2960);
            chk("beats_at_done", 32'(n), 32'(BEATS));
            start = 1'b0;
            fin = 1;
         end
         pv = pix_valid; pr = pix_ready;
         pd = pix_data; ps = pix_sol; pl = pix_last;
         if (pix_valid && pix_ready) n++;
         if (cut && !fin && pix_valid && n == cut_beat) begin
            if (cut_rst) begin
               rst = 1'b1;
               #1;
               chk("rst_outputs", 32'({rom_addr, rom_en, pix_valid, pix_data, pix_sol, pix_last, busy, done}), 32'd0);
               @(posedge clk); #1 rst = 1'b0;
            end else begin
               abort = 1'b1;
               @(posedge clk); #1 abort = 1'b0;
            end
            @(negedge clk);
            chk("cut_idle", 32'({busy, pix_valid, rom_en, done}), 32'd0);
            fin = 1;
         end
         if (!fin) begin
            @(posedge clk);
            cyc++;
            #1 pix_ready = rnd ? 1'($urandom) : 1'b1;
         end
      end
      chk("scan_finished", 32'(fin), 32'd1);
      if (!cut) begin
         @(negedge clk);
         chk("busy_after_done", 32'(busy), 32'd0);
         chk("done_count", 32'(dones), 32'd1);
      end
      start = 1'b0;
      pix_ready = 1'b1;
      watch_no_done(20);
   endtask

   initial begin
      logic [W-1:0] w;
      rst = 1'b1; start = 1'b0; abort = 1'b0; pix_ready = 1'b0; phase = 3'd0;
      for (int a = 0; a < 64; a++) begin
         w = '0;
         if (a < 24) for (int b = 0; b < W; b++) w[b] = 1'($urandom);
         mem[a] = w;
      end
      for (int b = 0; b < W; b++) garbage[b] = 1'($urandom);
      mem[0][W-1 -: 7] = 7'b1111110;
      mem[8][W-1 -: 8] = 8'b00000011;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", 32'({rom_addr, rom_en, pix_valid, pix_data, pix_sol, pix_last, busy, done}), 32'd0);
      rst = 1'b0;

      scan(0, 0, 0, -1, 0);
      scan(1, 0, 0, -1, 0);
      scan(3, 0, 0, -1, 0);
      scan(0, 1, 0, -1, 0);
      scan(0, 0, 0, 1280, 0);
      scan(2, 0, 0, -1, 0);
      scan(1, 1, 0, 1300, 1);
      scan(2, 1, 0, -1, 0);
      scan(4, 0, 1, -1, 0);

      @(posedge clk); #1 start = 1'b1; abort = 1'b1; phase = 3'd5;
      @(posedge clk); #1 start = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk("start_abort_idle", 32'({busy, rom_en, pix_valid}), 32'd0);
      watch_no_done(10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
